// File: rtl/acc_burst_capture.sv
// acc_burst_capture: re-aligns sample markers with the accumulator pipeline,
// turns each burst into a {sum, count, sat} word and buffers words in a
// show-ahead FIFO with a valid/ready output.
// Optional build macro: ACC_BURST_CAP_DROPCNT_EN adds the dropped_cnt port
// (saturating count of words lost to a full FIFO).
module acc_burst_capture #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [31:0]                   acc_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_sum,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_sat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ACC_BURST_CAP_DROPCNT_EN
  ,
  output logic [15:0]                   dropped_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [31:0]      sum;
    logic [CNT_W-1:0] count;
    logic             sat;
  } word_t;

  // Marker delay line, aligned with acc_value at its last stage
  logic [LATENCY-1:0] v_sr;
  logic [LATENCY-1:0] l_sr;
  logic               v_d;
  logic               l_d;

  // Burst tracking state
  logic [31:0]      base;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  // Capture datapath
  logic             cnt_clip;
  logic [CNT_W-1:0] cnt_inc;
  logic             capture;
  word_t            cap_word;

  // FIFO state
  word_t          mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [LW-1:0]  level_next;
  logic           full;
  logic           push;
  logic           pop;
  word_t          head;

  // Shift {valid, qualified last} through LATENCY stages; last without valid is masked
  always_ff @(posedge clk) begin
    if (reset) begin
      v_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= in_valid;
      l_sr[0] <= in_valid & in_last;
      for (int i = 1; i < int'(LATENCY); i++) begin
        v_sr[i] <= v_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  assign v_d = v_sr[LATENCY-1];
  assign l_d = l_sr[LATENCY-1];

  // Saturating increment and the word that a closing sample produces
  always_comb begin
    cnt_clip       = (cnt == CNT_MAX);
    cnt_inc        = cnt_clip ? cnt : cnt + CNT_W'(1);
    capture        = v_d & l_d;
    cap_word.sum   = acc_value - base;
    cap_word.count = cnt_inc;
    cap_word.sat   = sat | cnt_clip;
  end

  // Per-burst counter, sticky saturation flag and burst-boundary base
  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else if (v_d) begin
      if (l_d) begin
        base <= acc_value;
        cnt  <= '0;
        sat  <= 1'b0;
      end else begin
        cnt  <= cnt_inc;
        sat  <= sat | cnt_clip;
      end
    end
  end

  // Push/pop decisions; a full FIFO still accepts a write if the head leaves this cycle
  always_comb begin
    full       = (level == LW'(FIFO_DEPTH));
    pop        = (level != '0) & out_ready;
    push       = capture & (~full | pop);
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
    end
  end

  // FIFO storage; contents are only observable through valid occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_word;
  end

  // Show-ahead head, forced to zero while empty
  assign head       = mem[rd_ptr];
  assign out_valid  = (level != '0);
  assign out_sum    = out_valid ? head.sum   : '0;
  assign out_count  = out_valid ? head.count : '0;
  assign out_sat    = out_valid ? head.sat   : 1'b0;
  assign fifo_level = level;

`ifdef ACC_BURST_CAP_DROPCNT_EN
  logic drop;
  assign drop = capture & full & ~pop;

  // Saturating count of words lost to a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      dropped_cnt <= '0;
    end else if (drop && (dropped_cnt != 16'hFFFF)) begin
      dropped_cnt <= dropped_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/acc_burst_capture.md
Name: acc_burst_capture

Overview:
- Sits directly downstream of the 32-bit pipelined A+B+ACC accumulator and consumes its `final_acc` output.
- Re-aligns the upstream sample-valid/last markers with the accumulator's fixed pipeline latency.
- At each burst end, computes the burst sum as the delta from the previous burst boundary, plus a sample count.
- Buffers results in a small FIFO with a valid/ready output handshake toward the register/stream interface.

Parameters:
- LATENCY, 10, edges from A/B presentation at the accumulator input until `final_acc` includes that sample (range 1..32).
- CNT_W, 16, width of the per-burst sample counter.
- FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock, shared with the accumulator.
- reset  in  1  reset.
- in_valid  in  1  A/B presented to the accumulator this cycle are a real sample. Upstream drives A=B=0 when low.
- in_last  in  1  qualifies in_valid; this sample closes the burst.
- acc_value  in  32  accumulator `final_acc`.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_sum  out  32  burst sum, modulo 2^32.
- out_count  out  CNT_W  samples in burst, saturating.
- out_sat  out  1  out_count saturated.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- dropped_cnt  out  16  present only with the optional feature.

Behaviour:
- Reset is synchronous, active-high; clock is clk. The same reset drives the accumulator, and upstream holds A=B=0 while reset is high.
- Reset clears:
  - delay line, base register, burst counter, FIFO pointers;
  - out_valid=0, out_sum=0, out_count=0, out_sat=0, fifo_level=0, dropped_cnt=0.
- Delay line: LATENCY-deep shift register of {in_valid, in_last & in_valid}. Its tap outputs v_d and l_d are aligned with acc_value. Every tap resets to 0, so pipeline garbage after reset is never captured.
- in_last with in_valid=0 is ignored.
- Burst counter, advanced on v_d=1:
  - if l_d=0: cnt <= cnt+1, saturating at 2^CNT_W-1; the sticky sat flag sets on saturation.
  - if l_d=1: capture word {sum = acc_value - base (mod 2^32), count = cnt+1 (saturating), sat}; then base <= acc_value, cnt <= 0, sat <= 0.
- A burst of length 1 (in_valid & in_last on the same cycle) yields count=1.
- FIFO:
  - Write on capture; read on out_valid & out_ready. Show-ahead: out_* reflect the head combinationally from registered storage.
  - Capture into an empty FIFO gives out_valid=1 on the next cycle.
  - Full FIFO with capture and a simultaneous pop: the write is accepted and the level is unchanged.
  - Full FIFO with capture and no pop: the word is dropped and FIFO contents are unchanged.
  - Simultaneous push and pop at level 1: out_valid stays 1 and shows the new word.
- out_* hold stable while out_valid=1 and out_ready=0.
- Back-to-back bursts (last on consecutive cycles) capture one word per cycle.
- Wrap-around of acc_value is handled by the modular subtract. No overflow indication beyond 2^32 per burst.
- Reset mid-burst discards the partial burst and all in-flight delay-line entries.

Optional Feature:
- Macro: ACC_BURST_CAP_DROPCNT_EN.
- Defined:
  - The dropped_cnt port exists.
  - 16-bit counter increments on each capture lost to a full FIFO, saturating at 0xFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; drops are silent.

Test Plan:
- Reset, then 3 samples A+B = 5, 7, 9, with last on the third: after LATENCY+1 edges, out_valid=1, out_sum=21, out_count=3, out_sat=0.
- Two bursts of sums 100 and 0xFFFFFFF0 back-to-back, the second with 2 samples: outputs 100/1 then 0xFFFFFFF0/2, with modular delta across the accumulator wrap.
- out_ready=0 with 6 single-sample bursts (FIFO_DEPTH=4): fifo_level=4, 4 words retained in order, 2 dropped; dropped_cnt=2 when the macro is defined.
- FIFO full with out_ready=1 on the cycle a capture aligns: level stays 4 and no drop.
- CNT_W=4 with a 20-sample burst: out_count=15, out_sat=1. The next 1-sample burst gives count=1, sat=0.
- Reset asserted 3 cycles after in_last, before alignment: no word is ever written, out_valid stays 0, fifo_level=0.
